// File: rtl/ammrv_arbiter.sv
// Round-robin arbiter sharing one pipelined Avalon-MM master port (with
// readdatavalid) between N requesters. Outstanding reads are tracked in an
// in-order tag FIFO so each returned beat is steered back to its issuer.
module ammrv_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk1x,
  input  logic              reset,
  input  logic [N*AW-1:0]   s_address,
  input  logic [N*DW/8-1:0] s_byteenable,
  input  logic [N*DW-1:0]   s_writedata,
  input  logic [N-1:0]      s_read,
  input  logic [N-1:0]      s_write,
  output logic [N-1:0]      s_waitrequest,
  output logic [DW-1:0]     s_readdata,
  output logic [N-1:0]      s_readdatavalid,
  output logic [AW-1:0]     m_address,
  output logic [DW/8-1:0]   m_byteenable,
  output logic [DW-1:0]     m_writedata,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_waitrequest,
  input  logic [DW-1:0]     m_readdata,
  input  logic              m_readdatavalid,
  output logic              err
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = PW + 1;
  localparam int BW = DW / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] tag_q [MAX_OUT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          full;
  logic [N-1:0]  elig;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          busy;
  logic          g_read, g_write;
  logic          accept, push, pop;

  assign full    = (count_q == CW'(MAX_OUT));
  assign busy    = (state_q == BUSY);
  assign g_read  = s_read[grant_q];
  assign g_write = s_write[grant_q];
  assign accept  = busy & ~m_waitrequest & (g_read | g_write);
  // A read-and-write request is issued as a read, so it is held off at full too.
  assign push    = accept & g_read;
  assign pop     = m_readdatavalid & (count_q != '0);

  // Eligibility: any strobe, but reads wait while the tag FIFO is full.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = (s_read[i] | s_write[i]) & ~(s_read[i] & full);
    end
  end

  // Round-robin pick: first eligible index after the last accepted one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && elig[(int'(last_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(last_q) + k) % N);
      end
    end
  end

  // Arbitration FSM: grant in IDLE, hold the grant locked through stalls in BUSY.
  always_ff @(posedge clk1x or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointer/level and sticky protocol-error next-state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q
          | (busy & ~(g_read | g_write))
          | (busy & g_read & g_write)
          | (m_readdatavalid & (count_q == '0));
  end

  // Control registers; a reset discards every outstanding tag.
  always_ff @(posedge clk1x or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage: remembers which requester issued each accepted read.
  always_ff @(posedge clk1x) begin
    if (push) tag_q[wr_ptr_q] <= grant_q;
  end

  // Master port mirrors the granted requester while BUSY; read wins a double strobe.
  always_comb begin
    m_read       = busy & g_read;
    m_write      = busy & g_write & ~g_read;
    m_address    = busy ? s_address[int'(grant_q)*AW +: AW]      : '0;
    m_byteenable = busy ? s_byteenable[int'(grant_q)*BW +: BW]   : '0;
    m_writedata  = busy ? s_writedata[int'(grant_q)*DW +: DW]    : '0;
  end

  // Requester-side handshake and read-return steering.
  always_comb begin
    s_waitrequest   = '1;
    s_readdatavalid = '0;
    if (accept) s_waitrequest[grant_q] = 1'b0;
    if (pop)    s_readdatavalid[tag_q[rd_ptr_q]] = 1'b1;
    s_readdata = (reset & m_readdatavalid) ? m_readdata : '0;
  end

  assign err = err_q;

endmodule

// File: tb/tb_ammrv_arbiter.sv
// Directed bench for ammrv_arbiter (N=2, MAX_OUT=4): a vector table for the
// cycle-by-cycle protocol plus hand sequences for stalls, FIFO-full and reset.
module tb_ammrv_arbiter;

  localparam int N = 2, AW = 32, DW = 32, MAX_OUT = 4;
  localparam logic [31:0] A0 = 32'h0000_1000, D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'h0000_0020, D1 = 32'hCAFE_0001;
  localparam logic [3:0]  B0 = 4'hF, B1 = 4'h3;

  logic              clk1x = 1'b0;
  logic              reset;
  logic [N*AW-1:0]   s_address;
  logic [N*DW/8-1:0] s_byteenable;
  logic [N*DW-1:0]   s_writedata;
  logic [N-1:0]      s_read, s_write;
  logic [N-1:0]      s_waitrequest, s_readdatavalid;
  logic [DW-1:0]     s_readdata;
  logic [AW-1:0]     m_address;
  logic [DW/8-1:0]   m_byteenable;
  logic [DW-1:0]     m_writedata;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic              err;

  always #5 clk1x = ~clk1x;

  ammrv_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk1x(clk1x), .reset(reset),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  rd, wr;
    logic        mw, rdv;
    logic [31:0] rdata;
    logic        emr, emw;
    logic [31:0] ea;
    logic [1:0]  esw, esv;
    logic [31:0] esd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] rd, logic [1:0] wr, logic mw, logic rdv,
                              logic [31:0] rdata, logic emr, logic emw, logic [31:0] ea,
                              logic [1:0] esw, logic [1:0] esv, logic [31:0] esd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mw = mw; v.rdv = rdv; v.rdata = rdata;
    v.emr = emr; v.emw = emw; v.ea = ea; v.esw = esw; v.esv = esv; v.esd = esd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk1x);
    #1;
  endtask

  task automatic drive(input vec_t v);
    s_read = v.rd; s_write = v.wr; m_waitrequest = v.mw;
    m_readdatavalid = v.rdv; m_readdata = v.rdata;
  endtask

  // Drive one cycle's inputs, compare every output mid-cycle, then advance.
  task automatic apply(input vec_t v, input string nm);
    logic [31:0] ewd;
    logic [3:0]  ebe;
    drive(v);
    #2;
    ewd = (v.emr | v.emw) ? ((v.ea == A0) ? D0 : D1) : 32'h0;
    ebe = (v.emr | v.emw) ? ((v.ea == A0) ? B0 : B1) : 4'h0;
    chk({nm, " m_read"},   m_read,          v.emr);
    chk({nm, " m_write"},  m_write,         v.emw);
    chk({nm, " m_addr"},   m_address,       v.ea);
    chk({nm, " m_wdata"},  m_writedata,     ewd);
    chk({nm, " m_be"},     m_byteenable,    ebe);
    chk({nm, " s_wait"},   s_waitrequest,   v.esw);
    chk({nm, " s_rdv"},    s_readdatavalid, v.esv);
    chk({nm, " s_rdata"},  s_readdata,      v.esd);
    chk({nm, " err"},      err,             1'b0);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_address    = {A1, A0};
    s_writedata  = {D1, D0};
    s_byteenable = {B1, B0};
    s_read = '0; s_write = '0; m_waitrequest = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'h77;
    reset = 1'b0;
    #2;
    chk("rst m_read",  m_read, 1'b0);
    chk("rst m_write", m_write, 1'b0);
    chk("rst m_addr",  m_address, 32'h0);
    chk("rst s_wait",  s_waitrequest, 2'b11);
    chk("rst s_rdv",   s_readdatavalid, 2'b00);
    chk("rst s_rdata", s_readdata, 32'h0);
    chk("rst err",     err, 1'b0);
    nxt(); nxt();
    reset = 1'b1;
    m_readdatavalid = 1'b0;

    // Round-robin: both write continuously, grants 0,1,0,1.
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  3, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, A0, 2, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  3, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, A1, 1, 0, 0));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0));
    // Single write from requester 0.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, A0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0));
    // Read routing r0, r1, r0 with late responses.
    tbl.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,     1, 0, A0, 2, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,     0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0,     1, 0, A1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,     1, 0, A0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h11,  0, 0, 0,  3, 1, 'h11));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h22,  0, 0, 0,  3, 2, 'h22));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,  3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h33,  0, 0, 0,  3, 1, 'h33));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Stall hold: requester 1 reads under a 5-cycle stall, requester 0 waits.
    apply(mk(2, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0), "stall_idle");
    for (int i = 0; i < 5; i++) apply(mk(2, 1, 1, 0, 0, 1, 0, A1, 3, 0, 0), $sformatf("stall%0d", i));
    apply(mk(2, 1, 0, 0, 0,     1, 0, A1, 1, 0, 0),     "stall_acc");
    apply(mk(0, 1, 0, 0, 0,     0, 0, 0,  3, 0, 0),     "stall_next_idle");
    apply(mk(0, 1, 0, 0, 0,     0, 1, A0, 2, 0, 0),     "stall_next_r0");
    apply(mk(0, 0, 0, 1, 'h44,  0, 0, 0,  3, 2, 'h44),  "stall_ret");

    // FIFO full: four reads alternating 1,0,1,0 fill the tag FIFO.
    for (int i = 0; i < 4; i++) begin
      apply(mk(3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0), $sformatf("fill_idle%0d", i));
      apply(mk(3, 0, 0, 0, 0, 1, 0, (i % 2 == 0) ? A1 : A0,
               (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0), $sformatf("fill_acc%0d", i));
    end
    apply(mk(2, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0), "full_idle");
    apply(mk(2, 1, 0, 0, 0, 0, 1, A0, 2, 0, 0), "full_write");
    apply(mk(2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0), "full_block0");
    apply(mk(2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0), "full_block1");
    apply(mk(2, 0, 0, 1, 'h55, 0, 0, 0, 3, 2, 'h55), "full_pop");
    apply(mk(2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0), "full_grant");
    apply(mk(2, 0, 0, 0, 0, 1, 0, A1, 1, 0, 0), "full_read");
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 0, 1, 32'h60 + i, 0, 0, 0, 3, (i % 2 == 0) ? 2'b01 : 2'b10, 32'h60 + i),
            $sformatf("drain%0d", i));

    // Stray readdatavalid with nothing outstanding.
    drive(mk(0, 0, 0, 1, 'h99, 0, 0, 0, 0, 0, 0));
    #2;
    chk("stray s_rdv",   s_readdatavalid, 2'b00);
    chk("stray s_rdata", s_readdata, 32'h99);
    nxt();
    m_readdatavalid = 1'b0;
    #2;
    chk("stray err", err, 1'b1);
    nxt();

    // Reset in the middle of a stalled read with one read already outstanding.
    s_read = 2'b01; m_waitrequest = 1'b0;
    nxt();                     // IDLE -> grant 0
    #2;
    chk("mid acc m_read", m_read, 1'b1);
    nxt();                     // accepted, one tag outstanding
    nxt();                     // IDLE -> grant 0 again
    m_waitrequest = 1'b1;
    #2;
    chk("mid busy m_read", m_read, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid rst m_read",  m_read, 1'b0);
    chk("mid rst m_write", m_write, 1'b0);
    chk("mid rst m_addr",  m_address, 32'h0);
    chk("mid rst s_wait",  s_waitrequest, 2'b11);
    chk("mid rst err",     err, 1'b0);
    s_read = 2'b00; m_waitrequest = 1'b0;
    nxt();
    reset = 1'b1;
    m_readdatavalid = 1'b1; m_readdata = 32'hAB;
    #2;
    chk("post rst s_rdv", s_readdatavalid, 2'b00);
    nxt();
    m_readdatavalid = 1'b0;
    #2;
    chk("post rst err", err, 1'b1);

    // Double strobe: read wins and err is raised.
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    s_read = 2'b01; s_write = 2'b01;
    #2;
    chk("dbl idle err", err, 1'b0);
    nxt();
    #2;
    chk("dbl m_read",  m_read, 1'b1);
    chk("dbl m_write", m_write, 1'b0);
    chk("dbl s_wait",  s_waitrequest, 2'b10);
    nxt();
    s_read = 2'b00; s_write = 2'b00;
    #2;
    chk("dbl err", err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
